// File: rtl/tt_um_umar316798_alarm.sv
// Intrusion-alarm controller: armed / entry-delay / alarm FSM with latched sensors,
// a siren divider and a saturating alarm-event counter on the bidirectional pins.
module tt_um_umar316798_alarm #(
   parameter int unsigned ENTRY_DELAY = 16,
   parameter int unsigned SIREN_DIV   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [1:0] StDisarmed = 2'd0;
   localparam logic [1:0] StArmed    = 2'd1;
   localparam logic [1:0] StEntry    = 2'd2;
   localparam logic [1:0] StAlarm    = 2'd3;

   logic [4:0]           sync1_q, sync2_q;
   logic [1:0]           state_q, state_d;
   logic [7:0]           entry_cnt_q, entry_cnt_d;
   logic [SIREN_DIV-1:0] siren_q, siren_d;
   logic [2:0]           latch_q, latch_d;
   logic [7:0]           count_q, count_d;
   logic                 motion, door, window, arm, clear;
   logic                 unused_inputs;

   assign motion = sync2_q[0];
   assign door   = sync2_q[1];
   assign window = sync2_q[2];
   assign arm    = sync2_q[3];
   assign clear  = sync2_q[4];

   assign unused_inputs = ^{ena, uio_in, ui_in[7:5]};

   always_comb begin
      state_d     = state_q;
      entry_cnt_d = entry_cnt_q;
      unique case (state_q)
         StDisarmed: begin
            if (arm) state_d = StArmed;
         end
         StArmed: begin
            if (!arm) begin
               state_d = StDisarmed;
            end else if (motion || window) begin
               state_d = StAlarm;
            end else if (door) begin
               state_d     = StEntry;
               entry_cnt_d = 8'(ENTRY_DELAY - 1);
            end
         end
         StEntry: begin
            if (!arm) begin
               state_d = StDisarmed;
            end else if (motion || window || (entry_cnt_q == 8'd0)) begin
               state_d = StAlarm;
            end else begin
               entry_cnt_d = entry_cnt_q - 8'd1;
            end
         end
         StAlarm: begin
            if (!arm && clear) state_d = StDisarmed;
         end
         default: state_d = StDisarmed;
      endcase
   end

   // Flags clear on the edge that lands in DISARMED and never set from DISARMED.
   always_comb begin
      latch_d = latch_q;
      if (state_d == StDisarmed) begin
         latch_d = 3'b000;
      end else if (state_q != StDisarmed) begin
         latch_d = latch_q | {window, door, motion};
      end
   end

   // Divider restarts from zero on every entry into ALARM.
   assign siren_d = ((state_q == StAlarm) && (state_d == StAlarm)) ? siren_q + SIREN_DIV'(1)
                                                                    : '0;

   always_comb begin
      count_d = count_q;
      if ((state_d == StAlarm) && (state_q != StAlarm) && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         state_q     <= StDisarmed;
         entry_cnt_q <= '0;
         siren_q     <= '0;
         latch_q     <= '0;
         count_q     <= '0;
      end else begin
         sync1_q     <= ui_in[4:0];
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         entry_cnt_q <= entry_cnt_d;
         siren_q     <= siren_d;
         latch_q     <= latch_d;
         count_q     <= count_d;
      end
   end

   assign uo_out = {1'b0,
                    (state_q == StAlarm) & siren_q[SIREN_DIV-1],
                    latch_q,
                    state_q == StEntry,
                    state_q != StDisarmed,
                    state_q == StAlarm};
   assign uio_out = count_q;
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_umar316798_alarm.sv
// Scoreboard bench for the alarm controller: tasks push expected pin values with the
// cycle they are due, then pop and compare once the DUT reaches that cycle.
module tb_tt_um_umar316798_alarm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;

   tt_um_umar316798_alarm #(
      .ENTRY_DELAY (16),
      .SIREN_DIV   (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      string      name;
      logic [7:0] uo;
      logic [7:0] mask;
      logic [7:0] uio;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   ev = 0;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push_exp(input int due, input string name, input logic [7:0] uo,
                           input logic [7:0] mask, input logic [7:0] uio);
      exp_t e;
      e.due  = due;
      e.name = name;
      e.uo   = uo;
      e.mask = mask;
      e.uio  = uio;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      exp_t e;
      int   c;
      rst   = 1'b1;
      ui_in = 8'h00;
      step();
      step();
      rst = 1'b0;
      c   = cyc;
      for (int k = 1; k <= 20; k++) push_exp(c + k, "reset_idle", 8'h00, 8'hFF, 8'h00);
      for (int i = 0; i < 20; i++) begin
         ui_in = 8'h00;
         step();
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if ((uo_out & e.mask) !== (e.uo & e.mask) || uio_out !== e.uio || uio_oe !== 8'hFF)
            begin
               miscompares++;
               $display("FAIL %s @%0d: got uo_out=%h uio_out=%h uio_oe=%h, want uo_out=%h/%h uio_out=%h uio_oe=ff",
                        e.name, cyc, uo_out, uio_out, uio_oe, e.uo, e.mask, e.uio);
            end
         end
      end
   endtask

   task automatic test_disarmed_sweep();
      exp_t e;
      int   c = cyc;
      for (int p = 0; p < 8; p++) begin
         push_exp(c + 4 * p + 3, "disarmed_sweep", 8'h00, 8'hFF, 8'(ev));
         push_exp(c + 4 * p + 4, "disarmed_sweep", 8'h00, 8'hFF, 8'(ev));
      end
      for (int i = 0; i < 35; i++) begin
         ui_in = (i < 32) ? 8'(i / 4) : 8'h00;
         step();
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if ((uo_out & e.mask) !== (e.uo & e.mask) || uio_out !== e.uio || uio_oe !== 8'hFF)
            begin
               miscompares++;
               $display("FAIL %s @%0d: got uo_out=%h uio_out=%h uio_oe=%h, want uo_out=%h/%h uio_out=%h uio_oe=ff",
                        e.name, cyc, uo_out, uio_out, uio_oe, e.uo, e.mask, e.uio);
            end
         end
      end
   endtask

   // Arm, then a one-cycle window pulse; alarm lands at c+6 and the siren runs.
   task automatic test_window_alarm();
      exp_t e;
      int   c = cyc;
      int   a = c + 6;
      push_exp(c + 3, "armed", 8'h02, 8'hFF, 8'(ev));
      push_exp(c + 5, "armed_before_window", 8'h02, 8'hFF, 8'(ev));
      ev++;
      push_exp(a, "window_alarm", 8'h23, 8'hFF, 8'(ev));
      push_exp(a + 7, "siren_low", 8'h23, 8'hFF, 8'(ev));
      push_exp(a + 8, "siren_rise", 8'h63, 8'hFF, 8'(ev));
      push_exp(a + 15, "siren_high", 8'h63, 8'hFF, 8'(ev));
      push_exp(a + 16, "siren_fall", 8'h23, 8'hFF, 8'(ev));
      push_exp(a + 24, "siren_rise2", 8'h63, 8'hFF, 8'(ev));
      for (int i = 0; i < 31; i++) begin
         ui_in = (i == 3) ? 8'h0C : 8'h08;
         step();
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if ((uo_out & e.mask) !== (e.uo & e.mask) || uio_out !== e.uio || uio_oe !== 8'hFF)
            begin
               miscompares++;
               $display("FAIL %s @%0d: got uo_out=%h uio_out=%h uio_oe=%h, want uo_out=%h/%h uio_out=%h uio_oe=ff",
                        e.name, cyc, uo_out, uio_out, uio_oe, e.uo, e.mask, e.uio);
            end
         end
      end
   endtask

   task automatic test_alarm_exit();
      exp_t e;
      int   c = cyc;
      for (int k = 3; k <= 6; k++) push_exp(c + k, "clear_with_arm", 8'h23, 8'hBF, 8'(ev));
      for (int k = 9; k <= 12; k++) push_exp(c + k, "disarm_no_clear", 8'h23, 8'hBF, 8'(ev));
      push_exp(c + 14, "alarm_before_exit", 8'h23, 8'hBF, 8'(ev));
      push_exp(c + 15, "exit_disarmed", 8'h00, 8'hFF, 8'(ev));
      push_exp(c + 17, "exit_hold", 8'h00, 8'hFF, 8'(ev));
      for (int i = 0; i < 17; i++) begin
         ui_in = (i < 6) ? 8'h18 : (i < 12) ? 8'h00 : 8'h10;
         step();
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if ((uo_out & e.mask) !== (e.uo & e.mask) || uio_out !== e.uio || uio_oe !== 8'hFF)
            begin
               miscompares++;
               $display("FAIL %s @%0d: got uo_out=%h uio_out=%h uio_oe=%h, want uo_out=%h/%h uio_out=%h uio_oe=ff",
                        e.name, cyc, uo_out, uio_out, uio_oe, e.uo, e.mask, e.uio);
            end
         end
      end
      ui_in = 8'h00;
   endtask

   // Door entry aborted by disarm, then door entry left to time out after 16 cycles.
   task automatic test_entry();
      exp_t e;
      int   c = cyc;
      push_exp(c + 6, "entry_pending", 8'h16, 8'hFF, 8'(ev));
      push_exp(c + 10, "entry_still", 8'h16, 8'hFF, 8'(ev));
      push_exp(c + 11, "entry_disarm", 8'h00, 8'hFF, 8'(ev));
      push_exp(c + 21, "entry_no_alarm", 8'h00, 8'hFF, 8'(ev));
      push_exp(c + 25, "rearmed", 8'h02, 8'hFF, 8'(ev));
      push_exp(c + 28, "entry2_pending", 8'h16, 8'hFF, 8'(ev));
      push_exp(c + 43, "entry2_last", 8'h16, 8'hFF, 8'(ev));
      ev++;
      push_exp(c + 44, "entry_timeout_alarm", 8'h13, 8'hBF, 8'(ev));
      push_exp(c + 46, "timeout_alarm_hold", 8'h13, 8'hBF, 8'(ev));
      push_exp(c + 47, "timeout_cleared", 8'h00, 8'hFF, 8'(ev));
      for (int i = 0; i < 48; i++) begin
         if (i < 3) ui_in = 8'h08;
         else if (i == 3) ui_in = 8'h0A;
         else if (i < 8) ui_in = 8'h08;
         else if (i < 22) ui_in = 8'h00;
         else if (i == 25) ui_in = 8'h0A;
         else if (i < 44) ui_in = 8'h08;
         else ui_in = 8'h10;
         step();
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if ((uo_out & e.mask) !== (e.uo & e.mask) || uio_out !== e.uio || uio_oe !== 8'hFF)
            begin
               miscompares++;
               $display("FAIL %s @%0d: got uo_out=%h uio_out=%h uio_oe=%h, want uo_out=%h/%h uio_out=%h uio_oe=ff",
                        e.name, cyc, uo_out, uio_out, uio_oe, e.uo, e.mask, e.uio);
            end
         end
      end
   endtask

   task automatic test_saturation_and_reset();
      exp_t e;
      int   c;
      for (int j = 0; j < 260; j++) begin
         c  = cyc;
         ev = (ev >= 255) ? 255 : ev + 1;
         push_exp(c + 4, "loop_alarm", 8'h0B, 8'hBF, 8'(ev));
         push_exp(c + 7, "loop_cleared", 8'h00, 8'hFF, 8'(ev));
         for (int i = 0; i < 7; i++) begin
            ui_in = (i < 4) ? 8'h09 : 8'h10;
            step();
            while (sb.size() != 0 && sb[0].due <= cyc) begin
               e = sb.pop_front();
               vectors++;
               if ((uo_out & e.mask) !== (e.uo & e.mask) || uio_out !== e.uio || uio_oe !== 8'hFF)
               begin
                  miscompares++;
                  $display("FAIL %s @%0d: got uo_out=%h uio_out=%h uio_oe=%h, want uo_out=%h/%h uio_out=%h uio_oe=ff",
                           e.name, cyc, uo_out, uio_out, uio_oe, e.uo, e.mask, e.uio);
               end
            end
         end
      end
      c = cyc;
      push_exp(c + 4, "saturated_alarm", 8'h0B, 8'hBF, 8'hFF);
      push_exp(c + 5, "reset_mid_alarm", 8'h00, 8'hFF, 8'h00);
      push_exp(c + 8, "after_reset", 8'h00, 8'hFF, 8'h00);
      for (int i = 0; i < 8; i++) begin
         rst   = (i == 4);
         ui_in = (i < 4) ? 8'h09 : 8'h00;
         step();
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if ((uo_out & e.mask) !== (e.uo & e.mask) || uio_out !== e.uio || uio_oe !== 8'hFF)
            begin
               miscompares++;
               $display("FAIL %s @%0d: got uo_out=%h uio_out=%h uio_oe=%h, want uo_out=%h/%h uio_out=%h uio_oe=ff",
                        e.name, cyc, uo_out, uio_out, uio_oe, e.uo, e.mask, e.uio);
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_disarmed_sweep();
      test_window_alarm();
      test_alarm_exit();
      test_entry();
      test_saturation_and_reset();
      while (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         miscompares++;
         $display("FAIL %s: never checked, due @%0d, run ended @%0d", e.name, e.due, cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
